// File: rtl/axi_mctp_write_rx.sv
// AXI4 write slave that receives one MCTP-over-PCIe VDM packet per burst.
// Beat 0 carries the header; beats 1..AWLEN are forwarded as payload.
module axi_mctp_write_rx #(
  parameter logic [3:0]  EXP_HDR_VER   = 4'b0001,
  parameter logic [15:0] EXP_VENDOR_ID = 16'hB41A
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  // AW channel
  input  logic [6:0]   I_AWID,
  input  logic [63:0]  I_AWADDR,
  input  logic [7:0]   I_AWLEN,
  input  logic [2:0]   I_AWSIZE,
  input  logic [1:0]   I_AWBURST,
  input  logic         I_AWVALID,
  output logic         O_AWREADY,
  // W channel
  input  logic [255:0] I_WDATA,
  input  logic [31:0]  I_WSTRB,
  input  logic         I_WLAST,
  input  logic         I_WVALID,
  output logic         O_WREADY,
  // B channel
  output logic [6:0]   O_BID,
  output logic [1:0]   O_BRESP,
  output logic         O_BVALID,
  input  logic         I_BREADY,
  // header
  output logic         O_HDR_VALID,
  output logic [127:0] O_HDR,
  output logic         O_SOM,
  output logic         O_EOM,
  output logic         O_TO,
  output logic [1:0]   O_PKT_SEQ,
  output logic [2:0]   O_MSG_TAG,
  // payload
  output logic [255:0] O_PLD_DATA,
  output logic         O_PLD_VALID,
  output logic         O_PLD_LAST,
  input  logic         I_PLD_READY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           awready_q, awready_d;
  logic [6:0]     awid_q, awid_d;
  logic [7:0]     awlen_q, awlen_d;
  logic [7:0]     beat_q, beat_d;
  logic           drop_q, drop_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           msg_open_q, msg_open_d;
  logic [1:0]     exp_seq_q, exp_seq_d;
  logic           hdr_valid_q, hdr_valid_d;
  logic [127:0]   hdr_q, hdr_d;
  logic [255:0]   pld_data_q, pld_data_d;
  logic           pld_valid_q, pld_valid_d;
  logic           pld_last_q, pld_last_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [6:0]     bid_q, bid_d;

  logic           wready;
  logic           aw_fire;
  logic           w_fire;
  logic           b_fire;
  logic           is_last;
  logic           aw_bad;
  logic [127:0]   hdr_in;
  logic           hdr_legal;
  logic           hdr_som;
  logic           hdr_eom;
  logic [1:0]     hdr_seq;
  logic           seq_ok;
  logic           unused_sig;

  // Address and byte strobes carry no information for this packet sink.
  assign unused_sig = ^{I_AWADDR, I_WSTRB};

  // Handshake qualifiers and header decode of the incoming beat.
  always_comb begin
    wready    = (state_q == S_DATA) && !done_q &&
                ((beat_q == 8'd0) || drop_q ||
                 !pld_valid_q || I_PLD_READY);
    aw_fire   = (state_q == S_IDLE) && awready_q && I_AWVALID;
    w_fire    = wready && I_WVALID;
    b_fire    = bvalid_q && I_BREADY;
    is_last   = (beat_q == awlen_q);
    aw_bad    = (I_AWSIZE != 3'd5) || (I_AWBURST != 2'b01);
    hdr_in    = I_WDATA[127:0];
    hdr_som   = hdr_in[127];
    hdr_eom   = hdr_in[126];
    hdr_seq   = hdr_in[125:124];
    hdr_legal = (hdr_in[7:5] == 3'b011) &&
                (hdr_in[4:3] == 2'b10) &&
                (hdr_in[63:56] == 8'h7F) &&
                ({hdr_in[95:88], hdr_in[87:80]} == EXP_VENDOR_ID) &&
                (hdr_in[99:96] == EXP_HDR_VER);
    seq_ok    = hdr_som ||
                (msg_open_q && (hdr_seq == exp_seq_q));
  end

  // Next-state logic for the burst FSM, header, payload and response.
  always_comb begin
    state_d     = state_q;
    awid_d      = awid_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    drop_d      = drop_q;
    err_d       = err_q;
    done_d      = done_q;
    msg_open_d  = msg_open_q;
    exp_seq_d   = exp_seq_q;
    hdr_valid_d = 1'b0;
    hdr_d       = hdr_q;
    pld_data_d  = pld_data_q;
    pld_valid_d = pld_valid_q;
    pld_last_d  = pld_last_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;

    if (pld_valid_q && I_PLD_READY) begin
      pld_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (aw_fire) begin
          awid_d  = I_AWID;
          awlen_d = I_AWLEN;
          beat_d  = 8'd0;
          done_d  = 1'b0;
          drop_d  = aw_bad;
          err_d   = aw_bad;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          beat_d = beat_q + 8'd1;
          if (I_WLAST != is_last) begin
            err_d = 1'b1;
          end
          if (is_last) begin
            done_d = 1'b1;
          end
          if (beat_q == 8'd0) begin
            hdr_d       = hdr_in;
            hdr_valid_d = 1'b1;
            if (!hdr_legal || !seq_ok) begin
              drop_d = 1'b1;
            end
            if (hdr_legal && seq_ok) begin
              exp_seq_d  = hdr_seq + 2'd1;
              msg_open_d = !hdr_eom;
            end
          end else if (!drop_q) begin
            pld_data_d  = I_WDATA;
            pld_valid_d = 1'b1;
            pld_last_d  = is_last;
          end
        end
        // Respond only once the final payload beat has left.
        if (done_d && !pld_valid_d) begin
          state_d  = S_RESP;
          bvalid_d = 1'b1;
          bid_d    = awid_q;
          bresp_d  = (drop_d || err_d) ? 2'b10 : 2'b00;
        end
      end
      S_RESP: begin
        if (b_fire) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign awready_d = (state_d == S_IDLE);

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      awid_q      <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      msg_open_q  <= 1'b0;
      exp_seq_q   <= '0;
      hdr_valid_q <= 1'b0;
      hdr_q       <= '0;
      pld_data_q  <= '0;
      pld_valid_q <= 1'b0;
      pld_last_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      bid_q       <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      awid_q      <= awid_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      done_q      <= done_d;
      msg_open_q  <= msg_open_d;
      exp_seq_q   <= exp_seq_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_q       <= hdr_d;
      pld_data_q  <= pld_data_d;
      pld_valid_q <= pld_valid_d;
      pld_last_q  <= pld_last_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
    end
  end

  assign O_AWREADY   = awready_q;
  assign O_WREADY    = wready;
  assign O_BID       = bid_q;
  assign O_BRESP     = bresp_q;
  assign O_BVALID    = bvalid_q;
  assign O_HDR_VALID = hdr_valid_q;
  assign O_HDR       = hdr_q;
  assign O_SOM       = hdr_q[127];
  assign O_EOM       = hdr_q[126];
  assign O_PKT_SEQ   = hdr_q[125:124];
  assign O_TO        = hdr_q[123];
  assign O_MSG_TAG   = hdr_q[122:120];
  assign O_PLD_DATA  = pld_data_q;
  assign O_PLD_VALID = pld_valid_q;
  assign O_PLD_LAST  = pld_last_q;

endmodule

// File: doc/axi_mctp_write_rx.md
AXI_MCTP_WRITE_RX -- requirements
Module: axi_mctp_write_rx

Interface
REQ-001 SHALL have parameter EXP_HDR_VER, default 4'b0001, the only accepted MCTP header version.
REQ-002 SHALL have parameter EXP_VENDOR_ID, default 16'hB41A, the accepted {hdr[95:88],hdr[87:80]} value.
REQ-003 SHALL have port i_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have AW ports: I_AWID in 7, I_AWADDR in 64, I_AWLEN in 8, I_AWSIZE in 3, I_AWBURST in 2, I_AWVALID in 1, O_AWREADY out 1.
REQ-006 SHALL have W ports: I_WDATA in 256, I_WSTRB in 32, I_WLAST in 1, I_WVALID in 1, O_WREADY out 1.
REQ-007 SHALL have B ports: O_BID out 7, O_BRESP out 2, O_BVALID out 1, I_BREADY in 1.
REQ-008 SHALL have header outputs: O_HDR_VALID out 1 (one-cycle pulse), O_HDR out 128, O_SOM, O_EOM, O_TO out 1 each, O_PKT_SEQ out 2, O_MSG_TAG out 3.
REQ-009 SHALL have payload outputs: O_PLD_DATA out 256, O_PLD_VALID out 1, O_PLD_LAST out 1, I_PLD_READY in 1.

Function
REQ-010 SHALL be an AXI4 write slave consuming one MCTP-over-PCIe VDM packet per burst; beat 0 carries header in WDATA[127:0], WDATA[255:128] of beat 0 discarded; beats 1..AWLEN forwarded as payload.
REQ-011 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE.
REQ-012 IDLE: O_AWREADY=1; on I_AWVALID&O_AWREADY capture AWID, AWLEN, size/burst legality, clear beat counter, go DATA; O_AWREADY=0 in all other states.
REQ-013 DATA: O_WREADY = (beat==0) || drop || !O_PLD_VALID || I_PLD_READY; beat accepted on I_WVALID&O_WREADY; counter 8-bit, increments per accepted beat.
REQ-014 Beat 0 accept: register header, pulse O_HDR_VALID next cycle; O_SOM=hdr[127], O_EOM=hdr[126], O_PKT_SEQ=hdr[125:124], O_TO=hdr[123], O_MSG_TAG=hdr[122:120]; hold until next header.
REQ-015 Header SHALL be legal only if hdr[7:5]=3'b011, hdr[4:3]=2'b10, hdr[63:56]=8'h7F, vendor id=EXP_VENDOR_ID, hdr[99:96]=EXP_HDR_VER; illegal sets drop flag for the burst.
REQ-016 Sequence check: 2-bit expected-seq register; on legal header with SOM=1 accept any seq; SOM=0 requires seq==expected else drop; on accepted legal header expected=seq+1 (wraps 3->0); EOM=1 clears tracker to "no message open"; SOM=0 with no message open is a drop.
REQ-017 Payload: accepted beat n>=1 with drop=0 registers O_PLD_DATA=I_WDATA, O_PLD_VALID=1, O_PLD_LAST=(n==AWLEN); held until I_PLD_READY; dropped beats never assert O_PLD_VALID.
REQ-018 Burst end = accepted beat with counter==AWLEN; I_WLAST mismatch at any beat (set early or missing at end) sets error; burst still ends on count, never on WLAST.
REQ-019 AWSIZE!=3'd5 or AWBURST!=2'b01 SHALL set drop+error; beats still consumed.
REQ-020 AWLEN=0: header only, no payload beat, O_PLD_VALID never asserted.
REQ-021 RESP: O_BVALID=1, O_BID=captured AWID, O_BRESP=2'b10 (SLVERR) if drop or error else 2'b00; held stable until I_BREADY, then IDLE next cycle; enter RESP only after last payload beat handed off (O_PLD_VALID=0).
REQ-022 I_WSTRB SHALL be ignored; I_AWADDR ignored beyond capture.
REQ-023 I_WVALID in IDLE/RESP SHALL not be accepted (O_WREADY=0).

Reset
REQ-024 i_reset_n=0 at a rising edge SHALL force IDLE, O_AWREADY=0 that cycle then 1 after release, O_WREADY=0, O_BVALID=0, O_BRESP=0, O_BID=0, O_HDR_VALID=0, O_HDR=0, header field outputs 0, O_PLD_VALID=0, O_PLD_LAST=0, O_PLD_DATA=0, beat counter 0, seq tracker "no message open".
REQ-025 Reset mid-burst SHALL abandon the burst with no B response and no further payload.

Verification
REQ-026 Legal header SOM=1,EOM=1,seq0,ver1, AWLEN=2, payload AAAA.., BBBB.., ready=1 -> O_HDR_VALID pulse, two payload beats, LAST on BBBB.., BRESP=0, BID=AWID.
REQ-027 Same burst with hdr[99:96]=4'b0010 -> zero payload beats, all 3 W beats accepted, BRESP=2'b10.
REQ-028 Four bursts SOM/seq0, seq1, seq3, seq... -> third burst dropped with SLVERR, others OKAY.
REQ-029 AWLEN=3, I_PLD_READY toggled 1-0-0-1 -> O_WREADY stalls, payload data stable while VALID&!READY, no beat lost.
REQ-030 AWLEN=0 header-only, then WLAST asserted on beat 1 of AWLEN=2 burst -> first OKAY, no payload; second SLVERR with 3 beats consumed.
REQ-031 Reset asserted during beat 1 of AWLEN=2 -> all outputs at reset values, next burst processed normally with OKAY.
